// File: rtl/accumulator_sequencer_if.sv
// Command handshake plus datapath control bundle for accumulator_sequencer.
//   master : command source / datapath side (drives cmd_*, zf_in)
//   slave  : the sequencer (drives cmd_ready, bus_data, ctl_*, done, result_zf, op_count)
interface accumulator_sequencer_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = 8;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [DATA_W-1:0]  cmd_data;
    logic [DATA_W-1:0]  bus_data;
    logic               ctl_load_bus;
    logic               ctl_nla;
    logic               ctl_nlb;
    logic               ctl_ea;
    logic               ctl_eu;
    logic               ctl_sub;
    logic               ctl_bus_sel;
    logic               zf_in;
    logic               done;
    logic               result_zf;
    logic [CNT_W-1:0]   op_count;

    modport master (
        output cmd_valid, cmd_op, cmd_data, zf_in,
        input  cmd_ready, bus_data, ctl_load_bus, ctl_nla, ctl_nlb, ctl_ea,
               ctl_eu, ctl_sub, ctl_bus_sel, done, result_zf, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, zf_in,
        output cmd_ready, bus_data, ctl_load_bus, ctl_nla, ctl_nlb, ctl_ea,
               ctl_eu, ctl_sub, ctl_bus_sel, done, result_zf, op_count
    );
endinterface

// File: rtl/accumulator_sequencer.sv
// Microsequencer for the 8-bit adder/accumulator datapath. Accepts one
// LDA/ADD/SUB/NOP command at a time and expands it into the control-line
// sequence IDLE -> FETCH -> XFER -> [EXEC] -> DONE.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus.slave : cmd_valid/cmd_ready/cmd_op/cmd_data handshake, bus_data and
//               ctl_* datapath controls, zf_in from the datapath, done pulse,
//               result_zf and op_count status
module accumulator_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter bit          SHOW_BUS = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    accumulator_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDA = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic [2:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               load_bus_q, load_bus_d;
    logic               nla_q, nla_d;
    logic               nlb_q, nlb_d;
    logic               eu_q, eu_d;
    logic               sub_q, sub_d;
    logic               bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0]  bus_data_q, bus_data_d;
    logic               result_zf_q;
    logic [CNT_W-1:0]   op_count_q;

    // Next-state logic, then control decode of the next state/op so the
    // registered outputs line up with the state register.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        load_bus_d = 1'b0;
        nla_d      = 1'b1;
        nlb_d      = 1'b1;
        eu_d       = 1'b0;
        sub_d      = 1'b0;
        bus_sel_d  = 1'b0;
        bus_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    data_d  = bus.cmd_data;
                    state_d = (bus.cmd_op == OP_NOP) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_XFER;
            ST_XFER:  state_d = (op_q == OP_LDA) ? ST_DONE : ST_EXEC;
            ST_EXEC:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_FETCH: begin
                load_bus_d = 1'b1;
                bus_sel_d  = SHOW_BUS;
                bus_data_d = data_d;
            end
            ST_XFER: begin
                load_bus_d = 1'b1;
                bus_sel_d  = SHOW_BUS;
                bus_data_d = data_d;
                if (op_d == OP_LDA) begin
                    nla_d = 1'b0;
                end else begin
                    nlb_d = 1'b0;
                end
            end
            ST_EXEC: begin
                eu_d  = 1'b1;
                nla_d = 1'b0;
                sub_d = (op_d == OP_SUB);
            end
            ST_DONE: done_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    // State, latched command and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            load_bus_q  <= 1'b0;
            nla_q       <= 1'b1;
            nlb_q       <= 1'b1;
            eu_q        <= 1'b0;
            sub_q       <= 1'b0;
            bus_sel_q   <= 1'b0;
            bus_data_q  <= '0;
            result_zf_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            load_bus_q <= load_bus_d;
            nla_q      <= nla_d;
            nlb_q      <= nlb_d;
            eu_q       <= eu_d;
            sub_q      <= sub_d;
            bus_sel_q  <= bus_sel_d;
            bus_data_q <= bus_data_d;
            // ZF from EXEC is registered by the datapath, so it is valid in DONE.
            if (state_q == ST_DONE) begin
                result_zf_q <= bus.zf_in;
                if (op_q != OP_NOP) begin
                    op_count_q <= op_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.cmd_ready    = ready_q;
    assign bus.done         = done_q;
    assign bus.ctl_load_bus = load_bus_q;
    assign bus.ctl_nla      = nla_q;
    assign bus.ctl_nlb      = nlb_q;
    assign bus.ctl_ea       = 1'b0;
    assign bus.ctl_eu       = eu_q;
    assign bus.ctl_sub      = sub_q;
    assign bus.ctl_bus_sel  = bus_sel_q;
    assign bus.bus_data     = bus_data_q;
    assign bus.result_zf    = result_zf_q;
    assign bus.op_count     = op_count_q;
endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer with a behavioural model of
// the A/B/ALU/bus-buffer datapath driven by the sequencer's control lines.
module tb_accumulator_sequencer;
    localparam int unsigned DATA_W = 8;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       load_bus;
        logic       nla;
        logic       nlb;
        logic       ea;
        logic       eu;
        logic       sub;
        logic       bus_sel;
        logic [7:0] bus_data;
    } ctl_t;

    typedef struct packed {
        logic [7:0] a;
        logic       zf;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] a;
        logic       zf;
        logic [7:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    accumulator_sequencer_if #(.DATA_W(DATA_W)) sif();

    accumulator_sequencer #(.DATA_W(DATA_W), .SHOW_BUS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    // Datapath model: bus buffer, registers A/B, ALU with registered ZF.
    logic [7:0] dp_a   = 8'h00;
    logic [7:0] dp_b   = 8'h00;
    logic [7:0] dp_buf = 8'h00;
    logic       dp_zf  = 1'b0;
    logic [7:0] dp_alu;
    logic [7:0] dp_bus;

    assign dp_alu    = sif.ctl_sub ? dp_a - dp_b : dp_a + dp_b;
    assign dp_bus    = sif.ctl_eu ? dp_alu : (sif.ctl_load_bus ? dp_buf : 8'h00);
    assign sif.zf_in = dp_zf;

    always @(posedge clk) begin
        if (sif.ctl_load_bus) dp_buf <= sif.bus_data;
        if (!sif.ctl_nla)     dp_a   <= dp_bus;
        if (!sif.ctl_nlb)     dp_b   <= dp_bus;
        if (sif.ctl_eu)       dp_zf  <= (dp_alu == 8'h00);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus contention guard on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) check("contention", 32'(sif.ctl_load_bus & sif.ctl_eu), 32'd0);
    end

    function automatic ctl_t sample();
        ctl_t c;
        c.ready    = sif.cmd_ready;
        c.done     = sif.done;
        c.load_bus = sif.ctl_load_bus;
        c.nla      = sif.ctl_nla;
        c.nlb      = sif.ctl_nlb;
        c.ea       = sif.ctl_ea;
        c.eu       = sif.ctl_eu;
        c.sub      = sif.ctl_sub;
        c.bus_sel  = sif.ctl_bus_sel;
        c.bus_data = sif.bus_data;
        return c;
    endfunction

    function automatic ctl_t idle_vec();
        ctl_t c;
        c = '{ready: 1'b1, done: 1'b0, load_bus: 1'b0, nla: 1'b1, nlb: 1'b1, ea: 1'b0,
              eu: 1'b0, sub: 1'b0, bus_sel: 1'b0, bus_data: 8'h00};
        return c;
    endfunction

    function automatic ctl_t mask_hs(input ctl_t c);
        ctl_t m;
        m       = c;
        m.ready = 1'b0;
        m.done  = 1'b0;
        return m;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return (op == OP_NOP) ? 1 : ((op == OP_LDA) ? 3 : 4);
    endfunction

    // Expected control vector k cycles after the accept edge.
    function automatic ctl_t exp_trace(input logic [1:0] op, input int k, input logic [7:0] d);
        ctl_t c;
        int   lat;
        c       = idle_vec();
        c.ready = 1'b0;
        lat     = lat_of(op);
        if (k == lat) begin
            c.done = 1'b1;
        end else if (k == 1 || k == 2) begin
            c.load_bus = 1'b1;
            c.bus_sel  = 1'b1;
            c.bus_data = d;
            if (k == 2) begin
                if (op == OP_LDA) c.nla = 1'b0;
                else              c.nlb = 1'b0;
            end
        end else begin
            c.eu  = 1'b1;
            c.nla = 1'b0;
            c.sub = (op == OP_SUB);
        end
        return c;
    endfunction

    // Issue one command from an IDLE negedge; returns at the IDLE negedge after DONE.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                           input logic [7:0] ea, input logic ezf, input logic [7:0] ecnt);
        exp_t e;
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_data  = d;
        sb.push_back('{a: ea, zf: ezf, cnt: ecnt});
        for (int k = 1; k <= lat_of(op); k++) begin
            @(negedge clk);
            check("trace", 32'(sample()), 32'(exp_trace(op, k, d)));
            if (k == 1) begin
                sif.cmd_valid = 1'b0;
                sif.cmd_op    = 2'($urandom);
                sif.cmd_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        check("idle_after_done", 32'(sample()), 32'(idle_vec()));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check("acc_a", 32'(dp_a), 32'(e.a));
            check("result_zf", 32'(sif.result_zf), 32'(e.zf));
            check("op_count", 32'(sif.op_count), 32'(e.cnt));
        end
    endtask

    vec_t tbl[11];
    int   dones;
    logic [7:0] d;

    initial begin
        tbl[0]  = '{OP_LDA, 8'h2A, 8'h2A, 1'b0, 8'd1};
        tbl[1]  = '{OP_LDA, 8'h10, 8'h10, 1'b0, 8'd2};
        tbl[2]  = '{OP_ADD, 8'h05, 8'h15, 1'b0, 8'd3};
        tbl[3]  = '{OP_LDA, 8'h07, 8'h07, 1'b0, 8'd4};
        tbl[4]  = '{OP_SUB, 8'h07, 8'h00, 1'b1, 8'd5};
        tbl[5]  = '{OP_ADD, 8'hFF, 8'hFF, 1'b0, 8'd6};
        tbl[6]  = '{OP_ADD, 8'h01, 8'h00, 1'b1, 8'd7};
        tbl[7]  = '{OP_NOP, 8'h33, 8'h00, 1'b1, 8'd7};
        tbl[8]  = '{OP_LDA, 8'h80, 8'h80, 1'b1, 8'd8};
        tbl[9]  = '{OP_SUB, 8'h81, 8'hFF, 1'b0, 8'd9};
        tbl[10] = '{OP_ADD, 8'h01, 8'h00, 1'b1, 8'd10};

        sif.cmd_valid = 1'b0;
        sif.cmd_op    = OP_NOP;
        sif.cmd_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctl", 32'(mask_hs(sample())), 32'(mask_hs(idle_vec())));
        check("rst_done", 32'(sif.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ctl", 32'(sample()), 32'(idle_vec()));
        check("idle_count", 32'(sif.op_count), 32'd0);
        check("idle_zf", 32'(sif.result_zf), 32'd0);

        // Table-driven command sequence
        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i].op, tbl[i].data, tbl[i].a, tbl[i].zf, tbl[i].cnt);
        end

        // Asynchronous reset during EXEC of an ADD
        run_cmd(OP_LDA, 8'h10, 8'h10, 1'b1, 8'd11);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = OP_ADD;
        sif.cmd_data  = 8'h05;
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exec_eu", 32'(sif.ctl_eu), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctl", 32'(mask_hs(sample())), 32'(mask_hs(idle_vec())));
        check("async_rst_done", 32'(sif.done), 32'd0);
        check("async_rst_count", 32'(sif.op_count), 32'd0);
        check("async_rst_zf", 32'(sif.result_zf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(sample()), 32'(idle_vec()));
        end
        check("post_rst_a_held", 32'(dp_a), 32'h10);

        // NOP with cmd_valid held high: accepted once per IDLE visit
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = OP_NOP;
        sif.cmd_data  = 8'h5A;
        dones = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (sif.done) dones++;
            check("nop_ctl", 32'(mask_hs(sample())), 32'(mask_hs(idle_vec())));
            check("nop_ready", 32'(sif.cmd_ready), 32'(i % 2 == 0));
            if (i == 10) sif.cmd_valid = 1'b0;
        end
        @(negedge clk);
        check("nop_dones", 32'(dones), 32'd5);
        check("nop_count", 32'(sif.op_count), 32'd0);
        check("nop_zf", 32'(sif.result_zf), 32'd1);
        check("nop_idle", 32'(sample()), 32'(idle_vec()));

        // 256 back-to-back LDAs: op_count wraps 255 -> 0
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            run_cmd(OP_LDA, d, d, 1'b1, 8'(i + 1));
        end
        check("wrap_count", 32'(sif.op_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
Microsequencer for the 8-bit adder/accumulator datapath: register A, register B, the ALU and the ui_in bus buffer. It accepts one command at a time over a valid/ready handshake (LDA, ADD, SUB, NOP plus an 8-bit operand). It expands each command into the cycle-by-cycle control-line sequence the datapath needs, then reports completion with the resulting zero flag. It sits between a host/command source and the datapath control pins (nLa, nLb, Ea, Eu, sub, load-bus, bus/regA select), which it drives directly.

Parameters:
DATA_W, 8, operand/bus width
SHOW_BUS, 0, 1 = assert ctl_bus_sel during FETCH/XFER so uo_out mirrors the bus; 0 = ctl_bus_sel always 0 (uo_out shows regA)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  2  00 NOP, 01 LDA (A<=data), 10 ADD (A<=A+data), 11 SUB (A<=A-data)
cmd_data  in  DATA_W  operand
bus_data  out  DATA_W  operand presented to datapath ui_in
ctl_load_bus  out  1  datapath loading_onto_bus (active-high)
ctl_nla  out  1  A load, active-low
ctl_nlb  out  1  B load, active-low
ctl_ea  out  1  A output enable (held 0 by this block)
ctl_eu  out  1  ALU output enable
ctl_sub  out  1  ALU subtract select
ctl_bus_sel  out  1  uo_out select (1 = bus)
zf_in  in  1  registered ALU zero flag from datapath
done  out  1  one-cycle completion pulse
result_zf  out  1  zf_in sampled in DONE; holds until next DONE
op_count  out  8  number of completed non-NOP commands, wraps 255->0

Behaviour:
- States: IDLE, FETCH, XFER, EXEC, DONE. Control outputs are a pure decode of the state register plus the latched op (op_q); no combinational path from cmd_* to ctl_*.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op_q/data_q. Next state is DONE for NOP, otherwise FETCH. cmd_data/cmd_op are ignored outside IDLE.
- FETCH: ctl_load_bus=1, bus_data=data_q. The datapath buffer captures the operand on this edge. Next state XFER.
- XFER: ctl_load_bus=1, bus_data=data_q. For LDA: ctl_nla=0, next DONE. For ADD/SUB: ctl_nlb=0, next EXEC.
- EXEC: ctl_eu=1, ctl_load_bus=0, ctl_nla=0, ctl_sub=(op_q==SUB). A captures the ALU result and the ALU registers ZF on this edge. Next DONE.
- DONE: done=1 for exactly one cycle. result_zf<=zf_in. op_count increments if op_q!=NOP. Next IDLE.
- ctl_sub is 1 only in EXEC of SUB, so it is stable for the whole EXEC cycle. ctl_ea is always 0. At most one of {ctl_load_bus, ctl_eu} is high in any cycle, so there is no bus contention.
- Idle/default levels: ctl_nla=ctl_nlb=1, ctl_load_bus=ctl_eu=ctl_sub=ctl_ea=ctl_bus_sel=0, bus_data=0.
- Latency, counted from the accept edge to the cycle done is high: NOP 1, LDA 3, ADD/SUB 4. Accept-to-accept throughput is done+1 cycles, because a new command can be taken the cycle after DONE.
- Arithmetic is performed by the datapath, modulo 2^DATA_W. Carry is not observed.
- Reset (async, any state): state=IDLE, all outputs at default levels, result_zf=0, op_count=0, op_q/data_q=0. A command in flight is abandoned with no done pulse. Datapath registers are not cleared by this block.
- cmd_valid held high continuously is accepted once per IDLE visit. Back-to-back commands never overlap.

Test Plan:
- Reset then LDA 0x2A -> cmd_ready low 3 cycles. Trace: FETCH (load_bus=1, bus_data=2A), XFER (load_bus=1, nla=0), DONE pulse. Datapath A=0x2A, op_count=1.
- LDA 0x10, ADD 0x05 -> ADD trace: FETCH, XFER (nlb=0), EXEC (eu=1, nla=0, sub=0), DONE. A=0x15, result_zf=0, 4-cycle latency.
- LDA 0x07, SUB 0x07 -> EXEC has sub=1. A=0x00, result_zf=1. Then ADD 0xFF, ADD 0x01 -> A=0x00 (wrap), result_zf=1.
- NOP with cmd_valid held high -> done one cycle after accept, op_count unchanged, ctl_* never leave default levels.
- Assert rst during EXEC of ADD -> all ctl_* at default levels immediately (async), no done pulse, op_count=0, cmd_ready=1 after rst drops.
- 256 LDA commands back to back with SHOW_BUS=1 -> op_count wraps to 0. ctl_bus_sel=1 exactly in FETCH/XFER. ctl_load_bus and ctl_eu are never high together.
